rom_rr_port: RTL and testbench
==============================

ROM_RR_PORT -- requirements
Module: rom_rr_port

Interface
REQ-001 SHALL have parameter WIDTH, default 30, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 21, number of words; ADDRW = $clog2(DEPTH), with a minimum of 1.
REQ-003 SHALL have parameter CHANNELS, default 2, number of requesters, range 1..8.
REQ-004 SHALL have parameter INIT_F, default "", hex init file; empty string means no load.
REQ-005 SHALL have port clk, input, 1 bit; the single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit; asynchronous active-low reset.
REQ-007 SHALL have port req_valid, input, CHANNELS bits; per-channel read request.
REQ-008 SHALL have port req_addr, input, CHANNELS*ADDRW bits; channel c address in bits [c*ADDRW +: ADDRW].
REQ-009 SHALL have port req_ready, output, CHANNELS bits; one-hot grant, combinational from req_valid and the pointer.
REQ-010 SHALL have port rsp_valid, output, CHANNELS bits; one-hot, one-cycle pulse marking the owner of the response.
REQ-011 SHALL have port rsp_addr, output, ADDRW bits; address echo of the returned word.
REQ-012 SHALL have port rsp_data, output, WIDTH bits; the returned word.
REQ-013 SHALL have port rsp_oob, output, 1 bit; set when the returned address is >= DEPTH.

Function
REQ-014 SHALL hold the memory array of DEPTH x WIDTH, marked rom_style "block", loaded from INIT_F by $readmemh when INIT_F is non-empty; it is never written.
REQ-015 SHALL transfer a request on channel c in any cycle where req_valid[c] and req_ready[c] are both 1.
REQ-016 SHALL grant at most one channel per cycle; no channel is granted when req_valid is 0.
REQ-017 SHALL arbitrate round-robin: search starts at pointer rr_ptr and proceeds upward with wrap-around; after a grant to channel g, rr_ptr = (g+1) mod CHANNELS; with no grant, rr_ptr holds.
REQ-018 SHALL keep req_ready independent of any downstream state; the block accepts one request every cycle.
REQ-019 SHALL, for a transfer in cycle N, assert rsp_valid[c] in cycle N+L, where L=1 by default (see Configuration), with rsp_addr and rsp_data matching that request.
REQ-020 SHALL, for an out-of-range address (>= DEPTH), return rsp_data = 0 and rsp_oob = 1; otherwise rsp_oob = 0.
REQ-021 SHALL hold rsp_addr, rsp_data and rsp_oob at their last values while rsp_valid is all zero.
REQ-022 SHALL return responses strictly in grant order; back-to-back grants give back-to-back rsp_valid pulses.
REQ-023 SHALL, when CHANNELS = 1, reduce to req_ready = req_valid with no pointer logic effect.
REQ-024 SHALL tolerate a requester dropping req_valid without a grant; no state changes for that channel.

Reset
REQ-025 SHALL clear asynchronously on rst_n low: rr_ptr = 0, rsp_valid = 0, rsp_addr = 0, rsp_data = 0, rsp_oob = 0, and all pipeline valid bits = 0.
REQ-026 SHALL discard in-flight reads when reset asserts mid-operation; no rsp_valid pulse appears for them after release.
REQ-027 SHALL hold req_ready at 0 while rst_n is low; the memory contents are unaffected by reset.

Configuration
REQ-028 SHALL, with macro ROM_RR_PORT_OUTREG_EN defined, add one output register stage (L = 2) on valid, address, data and oob, with reset values as in REQ-025; without the macro, L = 1.

Verification
REQ-029 SHALL cover single request: INIT mem[i] = i*3, CHANNELS = 2, ch0 requests addr 5 -> rsp_valid = 01 after L cycles, rsp_data = 15, rsp_addr = 5.
REQ-030 SHALL cover contention: both channels valid continuously, addrs 2 and 7 -> grants alternate 01, 10, 01, 10, ...; rsp_data alternates 6 and 21.
REQ-031 SHALL cover out-of-range: DEPTH = 21, request addr 25 -> rsp_data = 0, rsp_oob = 1, rsp_addr = 25.
REQ-032 SHALL cover reset mid-flight: grant in cycle N, rst_n low in cycle N+1 before the response -> no rsp_valid afterwards; all outputs 0 and rr_ptr = 0 after release.
REQ-033 SHALL cover streaming: ch1 only, addrs 0..20 on consecutive cycles -> 21 consecutive rsp_valid = 10 pulses with data 0, 3, ..., 60, in both configurations of the macro.

Source files
------------

// File: rtl/rom_rr_port.sv
// Read-only memory shared by CHANNELS requesters through a round-robin arbiter.
// Define ROM_RR_PORT_OUTREG_EN to add an output register stage (latency 2 instead of 1).
module rom_rr_port #(
    parameter int WIDTH    = 30,
    parameter int DEPTH    = 21,
    parameter int CHANNELS = 2,
    parameter     INIT_F   = "",
    localparam int ADDRW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       req_valid,
    input  logic [CHANNELS*ADDRW-1:0] req_addr,
    output logic [CHANNELS-1:0]       req_ready,
    output logic [CHANNELS-1:0]       rsp_valid,
    output logic [ADDRW-1:0]          rsp_addr,
    output logic [WIDTH-1:0]          rsp_data,
    output logic                      rsp_oob
);

    localparam int PTRW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [ADDRW:0] DEPTH_W = (ADDRW+1)'(DEPTH);
    localparam logic [PTRW:0]  CH_W    = (PTRW+1)'(CHANNELS);

    (* rom_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

    logic [PTRW-1:0]       rr_ptr;
    logic [PTRW-1:0]       nxt_ptr;
    logic [2*CHANNELS-1:0] dbl;
    logic [CHANNELS-1:0]   rot;
    logic [CHANNELS-1:0]   grant;
    logic [PTRW:0]         sum;
    logic [PTRW:0]         inc;
    logic [PTRW-1:0]       gnt_idx;
    logic                  found;
    logic [ADDRW-1:0]      sel_addr;
    logic                  sel_oob;
    logic [WIDTH-1:0]      rd_data;

    // Rotate the request vector so the search always starts at bit 0.
    always_comb begin
        dbl     = {req_valid, req_valid} >> rr_ptr;
        rot     = dbl[CHANNELS-1:0];
        found   = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                sum   = {1'b0, rr_ptr} + (PTRW+1)'(i);
                if (sum >= CH_W) sum = sum - CH_W;
                gnt_idx = sum[PTRW-1:0];
            end
        end
        grant = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            grant[k] = found && rst_n && (gnt_idx == PTRW'(k));
        end
        inc = {1'b0, gnt_idx} + 1'b1;
        if (inc >= CH_W) inc = '0;
        nxt_ptr = inc[PTRW-1:0];
    end

    always_comb begin
        sel_addr = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (grant[k]) sel_addr = req_addr[k*ADDRW +: ADDRW];
        end
        sel_oob = ({1'b0, sel_addr} >= DEPTH_W);
        rd_data = sel_oob ? '0 : mem[sel_addr];
    end

    assign req_ready = grant;

    logic [CHANNELS-1:0] s1_valid;
    logic [ADDRW-1:0]    s1_addr;
    logic [WIDTH-1:0]    s1_data;
    logic                s1_oob;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            s1_valid <= '0;
            s1_addr  <= '0;
            s1_data  <= '0;
            s1_oob   <= 1'b0;
        end else begin
            s1_valid <= grant;
            if (|grant) begin
                rr_ptr  <= nxt_ptr;
                s1_addr <= sel_addr;
                s1_data <= rd_data;
                s1_oob  <= sel_oob;
            end
        end
    end

`ifdef ROM_RR_PORT_OUTREG_EN
    logic [CHANNELS-1:0] o_valid;
    logic [ADDRW-1:0]    o_addr;
    logic [WIDTH-1:0]    o_data;
    logic                o_oob;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= '0;
            o_addr  <= '0;
            o_data  <= '0;
            o_oob   <= 1'b0;
        end else begin
            o_valid <= s1_valid;
            if (|s1_valid) begin
                o_addr <= s1_addr;
                o_data <= s1_data;
                o_oob  <= s1_oob;
            end
        end
    end

    assign rsp_valid = o_valid;
    assign rsp_addr  = o_addr;
    assign rsp_data  = o_data;
    assign rsp_oob   = o_oob;
`else
    assign rsp_valid = s1_valid;
    assign rsp_addr  = s1_addr;
    assign rsp_data  = s1_data;
    assign rsp_oob   = s1_oob;
`endif

endmodule

// File: tb/tb_rom_rr_port.sv
// Scoreboard bench for rom_rr_port: memory holds mem[i] = i*3, two channels, depth 21.
module tb_rom_rr_port;

`ifdef ROM_RR_PORT_OUTREG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [9:0]  req_addr;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [4:0]  rsp_addr;
    logic [29:0] rsp_data;
    logic        rsp_oob;

    rom_rr_port #(.WIDTH(30), .DEPTH(21), .CHANNELS(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_addr  (rsp_addr),
        .rsp_data  (rsp_data),
        .rsp_oob   (rsp_oob)
    );

    typedef struct {
        int          due;
        logic [1:0]  oh;
        logic [4:0]  addr;
        logic [29:0] data;
        logic        oob;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          mptr = 0;
    logic [4:0]  last_addr = '0;
    logic [29:0] last_data = '0;
    logic        last_oob = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d", total);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [1:0] exp_grant(input logic [1:0] v);
        int g;
        if (v == 2'b00) return 2'b00;
        g = v[mptr] ? mptr : 1 - mptr;
        return (g == 0) ? 2'b01 : 2'b10;
    endfunction

    // Drive one request cycle from just after a falling edge; returns at the next falling edge.
    task automatic step(input logic [1:0] v, input int a0, input int a1);
        logic [1:0] eg;
        exp_t       e;
        int         a;
        req_valid = v;
        req_addr  = {5'(a1), 5'(a0)};
        #1;
        eg = exp_grant(v);
        chk("req_ready", 64'(req_ready), 64'(eg));
        if (eg != 2'b00) begin
            a      = eg[0] ? a0 : a1;
            e.due  = cyc + L;
            e.oh   = eg;
            e.addr = 5'(a);
            e.oob  = (a >= 21);
            e.data = (a >= 21) ? 30'd0 : 30'(a * 3);
            q.push_back(e);
            mptr   = eg[0] ? 1 : 0;
        end
        @(negedge clk);
    endtask

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rsp_valid !== 2'b00) begin
            if (q.size() == 0) begin
                chk("unexpected rsp_valid", 64'(rsp_valid), 64'd0);
            end else begin
                e = q.pop_front();
                chk("rsp cycle", 64'(cyc), 64'(e.due));
                chk("rsp_valid", 64'(rsp_valid), 64'(e.oh));
                chk("rsp_addr", 64'(rsp_addr), 64'(e.addr));
                chk("rsp_data", 64'(rsp_data), 64'(e.data));
                chk("rsp_oob", 64'(rsp_oob), 64'(e.oob));
                last_addr = e.addr;
                last_data = e.data;
                last_oob  = e.oob;
            end
        end else begin
            if (q.size() > 0 && q[0].due <= cyc) begin
                chk("missing rsp_valid", 64'(rsp_valid), 64'(q[0].oh));
                void'(q.pop_front());
            end
            chk("hold rsp_addr", 64'(rsp_addr), 64'(last_addr));
            chk("hold rsp_data", 64'(rsp_data), 64'(last_data));
            chk("hold rsp_oob", 64'(rsp_oob), 64'(last_oob));
        end
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_addr  = '0;
        for (int i = 0; i < 21; i++) dut.mem[i] = 30'(i * 3);
        @(negedge clk);
        #1;
        chk("reset req_ready", 64'(req_ready), 64'd0);
        chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset rsp_data", 64'(rsp_data), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);

        // single request: ch0 addr 5 -> 15
        step(2'b01, 5, 0);
        repeat (3) step(2'b00, 0, 0);

        // contention: ch0 addr 2 (6), ch1 addr 7 (21)
        repeat (6) step(2'b11, 2, 7);
        // ch0 gives up before being served while ch1 is preferred
        step(2'b11, 4, 9);
        step(2'b00, 4, 9);
        step(2'b10, 0, 20);

        // out-of-range
        step(2'b10, 0, 25);
        step(2'b01, 31, 0);
        repeat (3) step(2'b00, 0, 0);

        // reset while a read is in flight
        step(2'b01, 1, 0);
        req_valid = 2'b01;
        req_addr  = {5'd0, 5'd9};
        #1;
        chk("pre-reset req_ready", 64'(req_ready), 64'(exp_grant(2'b01)));
        #2;
        rst_n = 1'b0;
        q.delete();
        last_addr = '0;
        last_data = '0;
        last_oob  = 1'b0;
        mptr      = 0;
        req_valid = 2'b11;
        repeat (3) @(negedge clk);
        #1;
        chk("in-reset req_ready", 64'(req_ready), 64'd0);
        chk("in-reset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("in-reset rsp_addr", 64'(rsp_addr), 64'd0);
        rst_n = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);
        repeat (3) step(2'b00, 0, 0);
        // pointer back at 0: ch0 wins first
        step(2'b11, 3, 6);
        step(2'b11, 3, 6);
        repeat (3) step(2'b00, 0, 0);

        // streaming on ch1, addrs 0..20
        for (int a = 0; a < 21; a++) step(2'b10, 0, a);
        repeat (L + 3) step(2'b00, 0, 0);

        chk("queue drained", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
